spis_dma_write_arb: RTL and testbench
=====================================

Name: spis_dma_write_arb

Overview:
- Shares the single qpimem_arb write port between N burst DMA writers, e.g. several spis_dma_write_fifo instances, or one SPI-slave FIFO plus another DMA engine.
- Each requester drives the same do_write/next_word/addr/wdata protocol the FIFO uses.
- The arbiter grants one requester per burst, round-robin, and holds the grant until that burst has fully drained.
- Sits between the requesters and qpimem_arb in the SoC top level.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DRAIN_CYCLES, 2, cycles the grant is held after the granted requester drops do_write (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_do_write  in  N_REQ  per-requester burst request; bit i belongs to requester i.
- req_next_word  out  N_REQ  per-requester word-accepted strobe.
- req_addr  in  32*N_REQ  per-requester address; requester i at bits [32*i+31:32*i].
- req_wdata  in  32*N_REQ  per-requester write data; same packing as req_addr.
- qpimem_arb_do_write  out  1  write request to qpimem_arb.
- qpimem_arb_next_word  in  1  word-accepted strobe from qpimem_arb.
- qpimem_arb_addr  out  32  muxed address.
- qpimem_arb_wdata  out  32  muxed data.
- grant  out  N_REQ  one-hot current owner; all zero when idle.
- busy  out  1  high in GRANT or DRAIN.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, grant=0, busy=0, qpimem_arb_do_write=0, req_next_word=0, last_ptr=N_REQ-1.
- IDLE state:
  - Outputs: qpimem_arb_do_write=0, qpimem_arb_addr=0, qpimem_arb_wdata=0, req_next_word=0.
  - If any req_do_write bit is set, select the first set bit searching from last_ptr+1 upward, wrapping mod N_REQ.
  - Register the winner into grant (one-hot) and g_idx, set last_ptr=g_idx, go to GRANT.
  - Grant latency is 1 cycle from request to grant.
- GRANT state:
  - qpimem_arb_do_write = req_do_write[g_idx], combinational, so a requester's drop reaches memory the same cycle.
  - qpimem_arb_addr and qpimem_arb_wdata are muxed combinationally from requester g_idx.
  - req_next_word[g_idx] = qpimem_arb_next_word; all other req_next_word bits = 0.
  - When req_do_write[g_idx]==0, load drain_cnt=DRAIN_CYCLES and go to DRAIN.
  - Requests from other requesters are ignored while in GRANT.
- DRAIN state:
  - Mux and next_word routing are held on g_idx, so the final in-flight word completes.
  - qpimem_arb_do_write is forced to 0, even if the owner re-asserts do_write.
  - drain_cnt decrements every cycle. When it reaches 1, go to IDLE and clear grant and busy.
- Back-to-back bursts: the earliest new grant is 1 cycle after leaving DRAIN. Total dead time between bursts is DRAIN_CYCLES+1 cycles.
- Fairness:
  - A requester that re-requests immediately still loses to any other pending requester, because the search starts at last_ptr+1.
  - With a single requester, it is re-granted every time.
- next_word while idle: a stray qpimem_arb_next_word in IDLE is dropped (not routed) and has no effect.
- Mid-burst reset: the arbiter goes to IDLE at once and qpimem_arb_do_write drops the same cycle. Requester and qpimem_arb recovery is their own concern.
- Self-check: grant is always zero or one-hot. busy == (grant != 0).

Optional Feature:
- Macro: SPIS_DMA_ARB_PRIO0_EN.
- Defined:
  - In IDLE, requester 0 wins whenever req_do_write[0]=1, regardless of last_ptr. last_ptr is still updated to the winner.
  - Intended for a latency-critical SPI receive path, so its FIFO never overflows behind a long competing burst.
  - Other requesters keep round-robin ordering among themselves.
- Undefined: pure round-robin as above. No extra logic is generated.

Test Plan:
- Reset, all requests low -> grant=0, busy=0, qpimem_arb_do_write=0 for 10 cycles; a stray next_word pulse leaves every req_next_word at 0.
- Req0 alone, 32-word burst at addr 0x1000, next_word every 2nd cycle -> grant=01 one cycle after request; exactly 32 pulses on req_next_word[0] and none on [1]; busy clears DRAIN_CYCLES(2)+1 cycles after req0 drops do_write.
- Req0 and req1 raised on the same cycle after reset -> req0 granted first (last_ptr=1); req1 granted 1 cycle after req0's DRAIN ends; the qpimem_arb_addr sequence shows req0's addresses then req1's, never interleaved.
- Req0 re-asserts during its own DRAIN while req1 is pending -> qpimem_arb_do_write stays 0 through DRAIN; the next grant goes to req1.
- Reset pulsed mid-burst (N_REQ=4, req2 granted, word 5 of 32) -> the next cycle shows grant=0 and qpimem_arb_do_write=0; after reset, req3 pending is granted before req2 (last_ptr back to 3, search starts at 0, only req3 set).
- With SPIS_DMA_ARB_PRIO0_EN defined, req1 and req0 pending and last_ptr=0 -> req0 granted; without the macro -> req1 granted.

Source files
------------

// File: rtl/spis_dma_write_arb_if.sv
// Write-port bundle between N burst DMA requesters, the arbiter and qpimem_arb.
// The arbiter connects through the slave modport; requesters and memory use master.
interface spis_dma_write_arb_if #(
   parameter int N_REQ = 2
);
   logic [N_REQ-1:0]    req_do_write;
   logic [N_REQ-1:0]    req_next_word;
   logic [32*N_REQ-1:0] req_addr;
   logic [32*N_REQ-1:0] req_wdata;
   logic                qpimem_arb_do_write;
   logic                qpimem_arb_next_word;
   logic [31:0]         qpimem_arb_addr;
   logic [31:0]         qpimem_arb_wdata;
   logic [N_REQ-1:0]    grant;
   logic                busy;

   modport slave (
      input  req_do_write, req_addr, req_wdata, qpimem_arb_next_word,
      output req_next_word, qpimem_arb_do_write, qpimem_arb_addr, qpimem_arb_wdata,
      grant, busy
   );

   modport master (
      output req_do_write, req_addr, req_wdata, qpimem_arb_next_word,
      input  req_next_word, qpimem_arb_do_write, qpimem_arb_addr, qpimem_arb_wdata,
      grant, busy
   );
endinterface

// File: rtl/spis_dma_write_arb.sv
// Round-robin burst arbiter sharing the qpimem_arb write port among N_REQ DMA writers.
// Optional macro SPIS_DMA_ARB_PRIO0_EN gives requester 0 absolute priority in IDLE.
module spis_dma_write_arb #(
   parameter int N_REQ        = 2,
   parameter int DRAIN_CYCLES = 2
) (
   input logic                 clk,
   input logic                 reset,
   spis_dma_write_arb_if.slave bus
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] g_idx, g_idx_nxt;
   logic [IDX_W-1:0] last_ptr, last_ptr_nxt;
   logic [IDX_W-1:0] win_idx;
   logic             win_found;
   logic [3:0]       drain_cnt, drain_cnt_nxt;
   logic [N_REQ-1:0] grant_r, grant_nxt;

   // Walk from the farthest candidate back to last_ptr+1 so the nearest set bit wins.
   always_comb begin
      logic [IDX_W-1:0] cand;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = IDX_W'((int'(last_ptr) + k) % N_REQ);
         if (bus.req_do_write[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
`ifdef SPIS_DMA_ARB_PRIO0_EN
      if (bus.req_do_write[0]) begin
         win_found = 1'b1;
         win_idx   = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         g_idx     <= '0;
         last_ptr  <= IDX_W'(N_REQ - 1);
         drain_cnt <= '0;
         grant_r   <= '0;
      end else begin
         state     <= state_nxt;
         g_idx     <= g_idx_nxt;
         last_ptr  <= last_ptr_nxt;
         drain_cnt <= drain_cnt_nxt;
         grant_r   <= grant_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      g_idx_nxt     = g_idx;
      last_ptr_nxt  = last_ptr;
      drain_cnt_nxt = drain_cnt;
      grant_nxt     = grant_r;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nxt          = GRANT;
               g_idx_nxt          = win_idx;
               last_ptr_nxt       = win_idx;
               grant_nxt          = '0;
               grant_nxt[win_idx] = 1'b1;
            end
         end
         GRANT: begin
            if (!bus.req_do_write[g_idx]) begin
               drain_cnt_nxt = 4'(DRAIN_CYCLES);
               state_nxt     = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_cnt <= 4'd1) begin
               state_nxt = IDLE;
               grant_nxt = '0;
            end else begin
               drain_cnt_nxt = drain_cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   // Mux and next_word routing stay on the owner through DRAIN; do_write only in GRANT.
   always_comb begin
      bus.qpimem_arb_do_write = 1'b0;
      bus.qpimem_arb_addr     = '0;
      bus.qpimem_arb_wdata    = '0;
      bus.req_next_word       = '0;
      if (state != IDLE) begin
         bus.qpimem_arb_addr      = bus.req_addr[32*g_idx +: 32];
         bus.qpimem_arb_wdata     = bus.req_wdata[32*g_idx +: 32];
         bus.req_next_word[g_idx] = bus.qpimem_arb_next_word;
      end
      if (state == GRANT && !reset) begin
         bus.qpimem_arb_do_write = bus.req_do_write[g_idx];
      end
   end

   assign bus.grant = grant_r;
   assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_spis_dma_write_arb.sv
// Scoreboard bench for spis_dma_write_arb: behavioural requesters and memory strobe,
// expected grants and words queued at issue time, popped by an independent monitor.
module tb_spis_dma_write_arb;
   localparam int N  = 4;
   localparam int DC = 2;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
   } word_t;

   logic clk;
   logic reset;
   spis_dma_write_arb_if #(.N_REQ(N)) bus();

   spis_dma_write_arb #(.N_REQ(N), .DRAIN_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   word_t       addr_q[$];
   logic [N-1:0] grant_q[$];

   bit          act[N];
   logic [31:0] base[N];
   int          idx[N];
   int          len[N];
   int          pulses[N];
   logic        phase, force_nw, rst_req, mon_en;
   logic [N-1:0] s_grant, s_rnw;
   logic        s_busy, s_dw;

   function automatic logic [31:0] wd(int i, int j);
      return 32'hD000_0000 | (32'(i) << 16) | 32'(j);
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] exp_v);
      n_tests++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp_v);
      end
   endtask

   task automatic flag(string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired", name);
   endtask

   // One clock: drive at negedge, strobe memory, sample before posedge, advance requesters.
   task automatic step();
      @(negedge clk);
      reset = rst_req;
      for (int i = 0; i < N; i++) begin
         bus.req_do_write[i]       = act[i];
         bus.req_addr[32*i +: 32]  = base[i] + 32'(4 * idx[i]);
         bus.req_wdata[32*i +: 32] = wd(i, idx[i]);
      end
      phase = ~phase;
      #1;
      bus.qpimem_arb_next_word = force_nw | (bus.qpimem_arb_do_write & phase);
      #3;
      s_grant = bus.grant;
      s_busy  = bus.busy;
      s_dw    = bus.qpimem_arb_do_write;
      s_rnw   = bus.req_next_word;
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (s_rnw[i]) begin
            pulses[i]++;
            idx[i]++;
            if (idx[i] >= len[i]) act[i] = 1'b0;
         end
      end
   endtask

   task automatic start_burst(int i, logic [31:0] b, int l);
      act[i]  = 1'b1;
      base[i] = b;
      idx[i]  = 0;
      len[i]  = l;
      grant_q.push_back(N'(1) << i);
      for (int j = 0; j < l; j++) addr_q.push_back('{addr: b + 32'(4 * j), wdata: wd(i, j)});
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) act[i] = 1'b0;
      rst_req = 1'b1;
      step();
      step();
      rst_req = 1'b0;
   endtask

   task automatic run_idle(string name);
      int n;
      bit any;
      n = 0;
      do begin
         step();
         n++;
         any = 1'b0;
         for (int i = 0; i < N; i++) any |= act[i];
      end while ((any || s_busy) && n < 3000);
      if (any || s_busy) flag(name);
   endtask

   task automatic step_while_active(int i, string name);
      for (int g = 0; g < 1000 && act[i]; g++) step();
      if (act[i]) flag(name);
   endtask

   // Independent monitor: structural invariants plus in-order grant and word checks.
   logic [N-1:0] prev_g = '0;
   always begin
      @(negedge clk);
      #4;
      if (mon_en) begin
         check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
         check("busy_vs_grant", 32'(bus.busy), 32'(bus.grant != '0));
         if (bus.grant != '0 && prev_g == '0) begin
            if (grant_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL grant_unexpected: got %0h expected none", bus.grant);
            end else begin
               check("grant_order", 32'(bus.grant), 32'(grant_q.pop_front()));
            end
         end
         if (bus.qpimem_arb_do_write && bus.qpimem_arb_next_word) begin
            if (addr_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL word_unexpected: got addr %0h expected none", bus.qpimem_arb_addr);
            end else begin
               word_t w;
               w = addr_q.pop_front();
               check("word_addr", bus.qpimem_arb_addr, w.addr);
               check("word_wdata", bus.qpimem_arb_wdata, w.wdata);
            end
         end
         prev_g = bus.grant;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset                    = 1'b1;
      rst_req                  = 1'b1;
      phase                    = 1'b0;
      force_nw                 = 1'b0;
      mon_en                   = 1'b0;
      bus.req_do_write         = '0;
      bus.req_addr             = '0;
      bus.req_wdata            = '0;
      bus.qpimem_arb_next_word = 1'b0;
      for (int i = 0; i < N; i++) begin
         act[i] = 1'b0; base[i] = '0; idx[i] = 0; len[i] = 0; pulses[i] = 0;
      end
      do_reset();
      mon_en = 1'b1;

      // Idle after reset, including a stray memory strobe.
      for (int c = 0; c < 10; c++) begin
         step();
         check("rst_grant", 32'(s_grant), 32'd0);
         check("rst_busy", 32'(s_busy), 32'd0);
         check("rst_do_write", 32'(s_dw), 32'd0);
      end
      force_nw = 1'b1;
      step();
      force_nw = 1'b0;
      check("stray_next_word", 32'(s_rnw), 32'd0);
      check("stray_busy", 32'(s_busy), 32'd0);

      // Single requester, 32-word burst.
      for (int i = 0; i < N; i++) pulses[i] = 0;
      start_burst(0, 32'h1000, 32);
      step();
      check("grant_lat_req_cycle", 32'(s_grant), 32'd0);
      step();
      check("grant_lat_next_cycle", 32'(s_grant), 32'd1);
      step_while_active(0, "burst0_timeout");
      n = 0;
      do begin step(); n++; end while (s_busy && n < 50);
      check("busy_clear_edges", 32'(n - 1), 32'(DC + 1));
      check("pulses_req0", 32'(pulses[0]), 32'd32);
      check("pulses_req1", 32'(pulses[1]), 32'd0);

      // Simultaneous req0/req1 after reset: req0 first, then req1 after DRAIN.
      do_reset();
      start_burst(0, 32'h2000, 4);
      start_burst(1, 32'h3000, 4);
      step_while_active(0, "burst2a_timeout");
      n = 0;
      do begin step(); n++; end while (s_grant != 4'b0010 && n < 50);
      check("regrant_edges", 32'(n), 32'(DC + 3));
      run_idle("burst2b_timeout");

      // Owner re-asserts during its DRAIN while req1 waits.
      do_reset();
      start_burst(0, 32'h4000, 4);
      step();
      step();
      start_burst(1, 32'h5000, 4);
      step_while_active(0, "burst3a_timeout");
      step();
      start_burst(0, 32'h6000, 2);
      for (int c = 0; c < DC + 1; c++) begin
         step();
         check("drain_do_write", 32'(s_dw), 32'd0);
      end
      run_idle("burst3b_timeout");

      // Mid-burst reset while req2 owns the port.
      do_reset();
      start_burst(2, 32'h7000, 32);
      for (int g = 0; g < 1000 && idx[2] < 5; g++) step();
      check("abort_word_idx", 32'(idx[2]), 32'd5);
      rst_req = 1'b1;
      step();
      check("rst_mid_do_write", 32'(s_dw), 32'd0);
      rst_req = 1'b0;
      act[2]  = 1'b0;
      step();
      check("rst_mid_grant", 32'(s_grant), 32'd0);
      check("rst_mid_do_write_after", 32'(s_dw), 32'd0);
      check("abort_words_left", 32'(addr_q.size()), 32'd27);
      addr_q.delete();
      start_burst(3, 32'h8000, 3);
      run_idle("burst4_timeout");

      // last_ptr=0 with req0 and req1 both pending.
      do_reset();
      start_burst(0, 32'h9000, 2);
      run_idle("burst5a_timeout");
`ifdef SPIS_DMA_ARB_PRIO0_EN
      start_burst(0, 32'hA000, 2);
      start_burst(1, 32'hB000, 2);
`else
      start_burst(1, 32'hB000, 2);
      start_burst(0, 32'hA000, 2);
`endif
      run_idle("burst5b_timeout");

      step();
      check("grant_q_empty", 32'(grant_q.size()), 32'd0);
      check("addr_q_empty", 32'(addr_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
